// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } rs_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int LOSS_CNT_W  = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for a single asynchronous level; chain cleared by rst_n.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the async input through the chain; last flop is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: waits for a stable PLL lock, then releases
// rst_out[0..NUM_STAGES-1] in order, STAGE_GAP cycles apart. Any lock loss or
// button press drops everything back to reset and the sequence restarts.
// Optional macro RESET_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter
// (lock_loss_count), counting locked drops seen while releasing or running.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_HOLD_CYCLES = 16,
  parameter int STAGE_GAP        = 4,
  parameter int NUM_STAGES       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  ext_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_released
`ifdef RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
`endif
);

  localparam int CNT_MAX = max_int(LOCK_HOLD_CYCLES, STAGE_GAP);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  logic locked_s, ext_s, fault;

  rs_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  all_rel_q, all_rel_d;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ext_rst),
    .q_o   (ext_s)
  );

  assign fault = !locked_s || ext_s;

  // Sequencer state: hold for lock, then peel stages off one at a time.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    all_rel_d = all_rel_q;
    case (state_q)
      WAIT_LOCK: begin
        rst_out_d = '1;
        all_rel_d = 1'b0;
        cnt_d     = '0;
        idx_d     = '0;
        if (!fault) state_d = HOLD;
      end
      HOLD: begin
        if (fault) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          cnt_d     = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = STAGE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STAGE: begin
        if (fault) begin
          // A partial release is abandoned, never resumed.
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          all_rel_d = 1'b0;
          cnt_d     = '0;
          idx_d     = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          for (int k = 0; k < NUM_STAGES; k++)
            if (idx_q == IDX_W'(k)) rst_out_d[k] = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d   = RUN;
            all_rel_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (fault) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          all_rel_d = 1'b0;
          cnt_d     = '0;
          idx_d     = '0;
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        rst_out_d = '1;
        all_rel_d = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset parks everything in full reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic                  locked_prev_q;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Count locked_s falling edges only while releasing or running; saturate.
  always_comb begin
    loss_d = loss_q;
    if (locked_prev_q && !locked_s && (state_q == STAGE || state_q == RUN) &&
        (loss_q != '1))
      loss_d = loss_q + LOSS_CNT_W'(1);
  end

  // Loss counter and previous-lock flop; cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_prev_q <= 1'b0;
      loss_q        <= '0;
    end else begin
      locked_prev_q <= locked_s;
      loss_q        <= loss_d;
    end
  end

  assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (defaults 16/4/3). Edge numbers below
// count from the first posedge that samples the new input level.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, pll_locked, ext_rst;
  logic [2:0] rst_out;
  logic       all_released;
`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .ext_rst         (ext_rst),
    .rst_out         (rst_out),
    .all_released    (all_released)
`ifdef RESET_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-computed release points: stage0 @23, stage1 @27, stage2 @31.
  function automatic logic [31:0] exp_rst(input int e);
    if (e < 23) return 32'h7;
    if (e < 27) return 32'h6;
    if (e < 31) return 32'h4;
    return 32'h0;
  endfunction

  task automatic run_seq(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      chk(tag, 32'(rst_out), exp_rst(e));
      if (e >= 30) chk({tag, "_allrel"}, 32'(all_released), (e >= 31) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop lock from RUN long enough to return to WAIT_LOCK, then relock.
  task automatic loss_event();
    @(negedge clk) pll_locked = 1'b0;
    edges(4);
    @(negedge clk) pll_locked = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; ext_rst = 1'b0;

    // Reset state
    edges(2);
    chk("rst_out_reset", 32'(rst_out), 32'h7);
    chk("allrel_reset", 32'(all_released), 32'd0);
`ifdef RESET_SEQ_LOSS_CNT_EN
    chk("loss_reset", 32'(lock_loss_count), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    edges(2);
    chk("rst_out_nolock", 32'(rst_out), 32'h7);

    // Test 1: nominal release
    @(negedge clk) pll_locked = 1'b1;
    run_seq("t1", 32);

    // Test 2: one-cycle lock glitch at HOLD cnt=10 (after edge 13)
    loss_event();
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      chk("t2_hold", 32'(rst_out), 32'h7);
    end
    @(negedge clk) pll_locked = 1'b0;
    edges(1);
    chk("t2_glitch", 32'(rst_out), 32'h7);
    @(negedge clk) pll_locked = 1'b1;
    run_seq("t2", 32);
`ifdef RESET_SEQ_LOSS_CNT_EN
    // one loss from the loss_event() above, none from the HOLD glitch
    chk("t2_loss", 32'(lock_loss_count), 32'd1);
`endif

    // Test 3: lock loss in RUN
    @(negedge clk) pll_locked = 1'b0;
    edges(2);
    chk("t3_edge2", 32'(rst_out), 32'h0);
    edges(1);
    chk("t3_edge3", 32'(rst_out), 32'h7);
    chk("t3_allrel", 32'(all_released), 32'd0);
`ifdef RESET_SEQ_LOSS_CNT_EN
    chk("t3_loss", 32'(lock_loss_count), 32'd2);
`endif
    edges(2);
    @(negedge clk) pll_locked = 1'b1;
    run_seq("t3", 32);

    // Test 4: ext_rst pulse just after stage 0 releases
    loss_event();
    run_seq("t4a", 23);
    @(negedge clk) ext_rst = 1'b1;
    for (int e = 24; e <= 28; e++) begin
      @(posedge clk); #1;
      chk("t4_ext", 32'(rst_out), (e < 26) ? 32'h6 : 32'h7);
    end
    @(negedge clk) ext_rst = 1'b0;
    run_seq("t4b", 32);
`ifdef RESET_SEQ_LOSS_CNT_EN
    chk("t4_loss", 32'(lock_loss_count), 32'd3);
`endif

    // Test 5: async reset mid-STAGE
    loss_event();
    run_seq("t5a", 27);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", 32'(rst_out), 32'h7);
    chk("t5_allrel", 32'(all_released), 32'd0);
`ifdef RESET_SEQ_LOSS_CNT_EN
    chk("t5_loss", 32'(lock_loss_count), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    run_seq("t5b", 32);

`ifdef RESET_SEQ_LOSS_CNT_EN
    // Test 6: saturation after 300 losses from RUN
    for (int i = 1; i <= 300; i++) begin
      loss_event();
      edges(32);
      if (i == 254) chk("t6_254", 32'(lock_loss_count), 32'd254);
    end
    chk("t6_sat", 32'(lock_loss_count), 32'd255);
    chk("t6_run", 32'(all_released), 32'd1);
    loss_event();
    edges(32);
    chk("t6_hold", 32'(lock_loss_count), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
